register_file_2r1w: RTL and testbench

//  - 32-entry general register file: two combinational read ports and one synchronous write port.
//  - Sits directly upstream of the operand latches. Feeds A/B operands to the execute stage; receives the write-back result.
//  - GR0 is hardwired to zero.
//  - Built-in scrub sequencer zeroes GR1..GR31, one entry per cycle, on request.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_wdec.sv | 18 +
 rtl/register_file_2r1w.sv | 71 +++++++
 tb/tb_register_file_2r1w.sv | 139 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the 2R1W register file
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    typedef enum logic {RF_IDLE, RF_SCRUB} rf_state_t;
    typedef logic [DATA_W-1:0] rf_word_t;
endpackage

// File: rtl/regfile_wdec.sv
// regfile_wdec: one-hot write decoder, GR0 never loads, no loads while scrubbing
module regfile_wdec
    import regfile_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int NR = NUM_REGS
) (
    input  logic [AW-1:0] RW,
    input  logic          WE,
    input  logic          Busy,
    output logic [NR-1:0] load
);
    always_comb begin
        load = '0;
        if (WE && !Busy) load[RW] = 1'b1;
        load[0] = 1'b0;
    end
endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 32x32 register file, two async reads, one sync write, scrub sequencer
// Optional write-through read bypass: define REGFILE_WRITE_BYPASS_EN.
module register_file_2r1w
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output rf_word_t          PA,
    output rf_word_t          PB,
    input  logic [ADDR_W-1:0] RW,
    input  rf_word_t          PW,
    input  logic              WE,
    input  logic              ClrReq,
    output logic              Busy
);
    rf_word_t          regs [NUM_REGS];
    rf_state_t         state;
    logic [ADDR_W-1:0] idx;
    logic [NUM_REGS-1:0] load;
    rf_word_t          rd_a, rd_b;

    regfile_wdec #(.AW(ADDR_W), .NR(NUM_REGS)) u_wdec (
        .RW   (RW),
        .WE   (WE),
        .Busy (Busy),
        .load (load)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            state <= RF_IDLE;
            idx   <= '0;
            Busy  <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (load[i]) regs[i] <= PW;
            case (state)
                RF_IDLE: if (ClrReq) begin
                    state <= RF_SCRUB;
                    idx   <= ADDR_W'(1);
                    Busy  <= 1'b1;
                end
                RF_SCRUB: begin
                    regs[idx] <= '0;
                    idx       <= idx + 1'b1;
                    if (idx == ADDR_W'(NUM_REGS - 1)) begin
                        state <= RF_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    assign rd_a = (RA == '0) ? '0 : regs[RA];
    assign rd_b = (RB == '0) ? '0 : regs[RB];

`ifdef REGFILE_WRITE_BYPASS_EN
    logic wr_ok;
    assign wr_ok = WE && !Busy && (RW != '0);
    assign PA = (wr_ok && RW == RA) ? PW : rd_a;
    assign PB = (wr_ok && RW == RB) ? PW : rd_b;
`else
    assign PA = rd_a;
    assign PB = rd_b;
`endif
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: directed self-checking bench for register_file_2r1w
module tb_register_file_2r1w;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  RA = '0, RB = '0, RW = '0;
    logic [31:0] PA, PB, PW = '0;
    logic        WE = 1'b0, ClrReq = 1'b0, Busy;
    int checks = 0;
    int errors = 0;

    register_file_2r1w dut (
        .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .PA(PA), .PB(PB),
        .RW(RW), .PW(PW), .WE(WE), .ClrReq(ClrReq), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RW = a; PW = d; WE = 1'b1;
        tick();
        WE = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        tick(); tick();
        Rst_n = 1'b1;
        tick();
        RA = 5'd5; RB = 5'd31; #1;
        checks++; if (PA !== 32'h0) begin errors++; $display("FAIL reset_pa got %h exp %h", PA, 32'h0); end
        checks++; if (PB !== 32'h0) begin errors++; $display("FAIL reset_pb got %h exp %h", PB, 32'h0); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    endtask

    task automatic test_write_read();
        wr(5'd3, 32'hDEADBEEF);
        RA = 5'd3; RB = 5'd4; #1;
        checks++; if (PA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_pa got %h exp %h", PA, 32'hDEADBEEF); end
        checks++; if (PB !== 32'h0) begin errors++; $display("FAIL wr_pb got %h exp %h", PB, 32'h0); end
        wr(5'd4, 32'h0BADF00D);
        checks++; if (PB !== 32'h0BADF00D) begin errors++; $display("FAIL wr_pb4 got %h exp %h", PB, 32'h0BADF00D); end
        checks++; if (PA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_pa_keep got %h exp %h", PA, 32'hDEADBEEF); end
    endtask

    task automatic test_gr0();
        wr(5'd0, 32'hCAFEBABE);
        RA = 5'd0; RB = 5'd0; #1;
        checks++; if (PA !== 32'h0) begin errors++; $display("FAIL gr0_pa got %h exp %h", PA, 32'h0); end
        checks++; if (PB !== 32'h0) begin errors++; $display("FAIL gr0_pb got %h exp %h", PB, 32'h0); end
    endtask

    task automatic test_bypass();
        RA = 5'd7; RB = 5'd7; RW = 5'd7; PW = 32'h12345678; WE = 1'b1; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        checks++; if (PA !== 32'h12345678) begin errors++; $display("FAIL byp_pa_pre got %h exp %h", PA, 32'h12345678); end
        checks++; if (PB !== 32'h12345678) begin errors++; $display("FAIL byp_pb_pre got %h exp %h", PB, 32'h12345678); end
`else
        checks++; if (PA !== 32'h0) begin errors++; $display("FAIL byp_pa_pre got %h exp %h", PA, 32'h0); end
        checks++; if (PB !== 32'h0) begin errors++; $display("FAIL byp_pb_pre got %h exp %h", PB, 32'h0); end
`endif
        tick();
        WE = 1'b0; #1;
        checks++; if (PA !== 32'h12345678) begin errors++; $display("FAIL byp_pa_post got %h exp %h", PA, 32'h12345678); end
        checks++; if (PB !== 32'h12345678) begin errors++; $display("FAIL byp_pb_post got %h exp %h", PB, 32'h12345678); end
    endtask

    task automatic test_scrub();
        int n = 0;
        int bad = 0;
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5A5A5);
        RA = 5'd17; #1;
        checks++; if (PA !== 32'hA5A5A5A5) begin errors++; $display("FAIL scrub_load got %h exp %h", PA, 32'hA5A5A5A5); end
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        while (Busy === 1'b1 && n < 100) begin
            if (n == 3) begin
                RA = 5'd3; RB = 5'd4; #1;
                checks++; if (PA !== 32'h0) begin errors++; $display("FAIL scrub_mid_done got %h exp %h", PA, 32'h0); end
                checks++; if (PB !== 32'hA5A5A5A5) begin errors++; $display("FAIL scrub_mid_old got %h exp %h", PB, 32'hA5A5A5A5); end
            end
            WE = (n == 20); RW = 5'd9; PW = 32'h11111111;
            ClrReq = (n == 25);
            tick();
            n++;
        end
        WE = 1'b0; ClrReq = 1'b0;
        checks++; if (n !== 31) begin errors++; $display("FAIL scrub_busy_cycles got %0d exp %0d", n, 31); end
        tick(); tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL scrub_no_restart got %b exp 0", Busy); end
        RA = 5'd9; #1;
        checks++; if (PA !== 32'h0) begin errors++; $display("FAIL scrub_gr9_drop got %h exp %h", PA, 32'h0); end
        for (int i = 1; i < 32; i++) begin
            RB = 5'(i); #1;
            if (PB !== 32'h0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL scrub_all_zero got %0d nonzero exp 0", bad); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wr(5'd2, 32'h22222222);
        wr(5'd30, 32'h30303030);
        ClrReq = 1'b1;
        tick();
        ClrReq = 1'b0;
        while (Busy === 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b exp 1", Busy); end
        Rst_n = 1'b0;
        RA = 5'd30; RB = 5'd2; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", Busy); end
        checks++; if (PA !== 32'h0) begin errors++; $display("FAIL rstmid_gr30 got %h exp %h", PA, 32'h0); end
        checks++; if (PB !== 32'h0) begin errors++; $display("FAIL rstmid_gr2 got %h exp %h", PB, 32'h0); end
        tick();
        Rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume got %b exp 0", Busy); end
        wr(5'd30, 32'h5A5A5A5A);
        RA = 5'd30; #1;
        checks++; if (PA !== 32'h5A5A5A5A) begin errors++; $display("FAIL rstmid_write_after got %h exp %h", PA, 32'h5A5A5A5A); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_gr0();
        test_bypass();
        test_scrub();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
